// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch halt/resume controller.
// Holds the FSM state encoding, the default debounce length and the width of
// the debounce counter used by btn_debounce.
package fetch_ctrl_pkg;

  // Default number of consecutive stable synchronized samples before a
  // button level is accepted (legal range 1..65535).
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 20000;

  // Debounce counter width; large enough for the full legal range above.
  localparam int unsigned DB_CNT_W = 16;

  // Fetch controller FSM states.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_RESUME = 2'd2
  } fetch_state_e;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_btn_debounce.sv
// btn_debounce: board push-button conditioner.
// 2-flop synchronizer, debounce counter and a registered falling-edge
// (release) detector. Reusable for any active-high board button.
// btn_db only changes after DEBOUNCE_CYCLES consecutive synchronized samples
// that differ from it; any sample equal to btn_db clears the counter.
// btn_release is high for the one cycle in which btn_db first reads 0 after 1.
module btn_debounce
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_db,
  output logic btn_release
);

  // Counter value at which the next differing sample flips btn_db.
  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                db_q, db_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                rel_q, rel_d;

  // Next-state logic: synchronizer shift, debounce count and release edge.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    if (sync2_q == db_q) begin
      // Stable sample: abandon any partial count.
      cnt_d = {DB_CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      // Enough consecutive differing samples: accept the new level.
      db_d  = sync2_q;
      cnt_d = {DB_CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + DB_CNT_W'(1);
    end
    // Pulse in the same cycle that btn_db first shows the released level.
    rel_d = db_q & ~db_d;
  end

  // Button path registers, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= {DB_CNT_W{1'b0}};
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_db      = db_q;
  assign btn_release = rel_q;

endmodule : btn_debounce

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: halt/resume controller for instruction fetch.
// Produces pc_en, the PC register load enable. Fetch stops when the decoder
// flags ecall and resumes for exactly one cycle (stepping past the ecall) on a
// debounced release of the continue button, then runs freely again.
// Optional feature macro: FETCH_CTRL_STEP_EN adds the step_mode input; while
// step_mode is high every executed instruction returns the controller to HALT.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned HALT_CNT_W      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ecall,
  input  logic                  continue_button,
`ifdef FETCH_CTRL_STEP_EN
  input  logic                  step_mode,
`endif
  output logic                  pc_en,
  output logic                  halted,
  output logic [HALT_CNT_W-1:0] halt_count
);

  localparam logic [1:0] S_RUN    = ST_RUN;
  localparam logic [1:0] S_HALT   = ST_HALT;
  localparam logic [1:0] S_RESUME = ST_RESUME;

  // Saturating increment for the halt counter.
  function automatic logic [HALT_CNT_W-1:0] sat_inc(input logic [HALT_CNT_W-1:0] v);
    logic [HALT_CNT_W-1:0] r;
    if (v == {HALT_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + HALT_CNT_W'(1);
    end
    return r;
  endfunction

  logic                  btn_db_s;
  logic                  btn_release_s;
  logic                  step_s;
  logic                  pc_en_s;
  logic [1:0]            state_q, state_d;
  logic                  halted_q, halted_d;
  logic [HALT_CNT_W-1:0] halt_count_q, halt_count_d;

`ifdef FETCH_CTRL_STEP_EN
  assign step_s = step_mode;
`else
  assign step_s = 1'b0;
`endif

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (continue_button),
    .btn_db      (btn_db_s),
    .btn_release (btn_release_s)
  );

  // FSM next state and halt bookkeeping. Release pulses outside HALT are
  // simply not looked at, so they are dropped rather than queued.
  always_comb begin
    state_d      = state_q;
    halt_count_d = halt_count_q;
    case (state_q)
      S_RUN: begin
        if (ecall) begin
          // The ecall wins over any coincident release.
          state_d      = S_HALT;
          halt_count_d = sat_inc(halt_count_q);
        end else if (step_s) begin
          // Single-step: one instruction fetched, then stop (not counted).
          state_d = S_HALT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        if (btn_release_s) begin
          state_d = S_RESUME;
        end else begin
          state_d = S_HALT;
        end
      end
      S_RESUME: begin
        if (step_s) begin
          state_d = S_HALT;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    halted_d = (state_d == S_HALT);
  end

  // PC load enable from the registered state and the live ecall flag.
  always_comb begin
    pc_en_s = 1'b0;
    case (state_q)
      S_RUN:    pc_en_s = ~ecall;
      S_HALT:   pc_en_s = 1'b0;
      S_RESUME: pc_en_s = 1'b1;
      default:  pc_en_s = 1'b0;
    endcase
  end

  // FSM and status registers, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RUN;
      halted_q     <= 1'b0;
      halt_count_q <= {HALT_CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      halted_q     <= halted_d;
      halt_count_q <= halt_count_d;
    end
  end

  // The PC never loads while reset is held.
  assign pc_en      = reset & pc_en_s;
  assign halted     = halted_q;
  assign halt_count = halt_count_q;

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl (DEBOUNCE_CYCLES=4).
module tb_fetch_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ecall = 1'b0;
  logic       continue_button = 1'b0;
`ifdef FETCH_CTRL_STEP_EN
  logic       step_mode = 1'b0;
`endif
  logic       pc_en;
  logic       halted;
  logic [7:0] halt_count;

  int vectors = 0;
  int miscompares = 0;

  fetch_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .HALT_CNT_W      (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ecall           (ecall),
    .continue_button (continue_button),
`ifdef FETCH_CTRL_STEP_EN
    .step_mode       (step_mode),
`endif
    .pc_en           (pc_en),
    .halted          (halted),
    .halt_count      (halt_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic p, input logic h, input logic [7:0] c);
    check({tag, "_pc_en"}, {31'd0, pc_en}, {31'd0, p});
    check({tag, "_halted"}, {31'd0, halted}, {31'd0, h});
    check({tag, "_halt_count"}, {24'd0, halt_count}, {24'd0, c});
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int pulses;

    // Reset held low: everything cleared and pc_en forced low.
    #2;
    check_out("reset_hold", 1'b0, 1'b0, 8'd0);
    tick();
    tick();
    check_out("reset_hold2", 1'b0, 1'b0, 8'd0);

    // Free run.
    reset = 1'b1;
    #1;
    check_out("first_run", 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_out("free_run", 1'b1, 1'b0, 8'd0);
    end

    // ecall halt: pc_en drops in the same cycle, halted after the edge.
    ecall = 1'b1;
    #1;
    check_out("ecall_pre", 1'b0, 1'b0, 8'd0);
    tick();
    check_out("ecall_halt", 1'b0, 1'b1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("halt_hold", 1'b0, 1'b1, 8'd1);
    end
    ecall = 1'b0;
    #1;
    check_out("halt_ecall_low", 1'b0, 1'b1, 8'd1);

    // Resume: press 10 cycles, release; pulse after edge r+6.
    continue_button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("press_in_halt", 1'b0, 1'b1, 8'd1);
    end
    check("btn_db_pressed", {31'd0, dut.u_debounce.btn_db}, 32'd1);
    continue_button = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_out("release_wait", 1'b0, 1'b1, 8'd1);
    end
    check("release_pulse", {31'd0, dut.u_debounce.btn_release}, 32'd1);
    tick();
    check_out("resume_pulse", 1'b1, 1'b0, 8'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("run_after_resume", 1'b1, 1'b0, 8'd1);
    end

    // Stray press/release in RUN is ignored.
    continue_button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("stray_press", 1'b1, 1'b0, 8'd1);
    end
    continue_button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("stray_release", 1'b1, 1'b0, 8'd1);
    end

    // ecall in the same cycle as a release in RUN: halt taken, release dropped.
    continue_button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("press2_run", 1'b1, 1'b0, 8'd1);
    end
    continue_button = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_out("release2_run", 1'b1, 1'b0, 8'd1);
    end
    check("release2_pulse", {31'd0, dut.u_debounce.btn_release}, 32'd1);
    ecall = 1'b1;
    #1;
    check_out("ecall_with_release", 1'b0, 1'b0, 8'd1);
    tick();
    check_out("halt_2", 1'b0, 1'b1, 8'd2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("no_queued_resume", 1'b0, 1'b1, 8'd2);
    end

    // 2-cycle glitch in HALT: no debounced change, no resume.
    continue_button = 1'b1;
    tick();
    tick();
    continue_button = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_out("glitch", 1'b0, 1'b1, 8'd2);
    end
    check("glitch_btn_db", {31'd0, dut.u_debounce.btn_db}, 32'd0);

    // Resume while ecall stays high: one RESUME cycle, then re-halt.
    continue_button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("press3", 1'b0, 1'b1, 8'd2);
    end
    continue_button = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_out("release3_wait", 1'b0, 1'b1, 8'd2);
    end
    tick();
    check_out("resume_over_ecall", 1'b1, 1'b0, 8'd2);
    tick();
    check_out("run_with_ecall", 1'b0, 1'b0, 8'd2);
    tick();
    check_out("halt_3", 1'b0, 1'b1, 8'd3);

    // Reset in HALT during a release debounce.
    ecall = 1'b0;
    continue_button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("press4", 1'b0, 1'b1, 8'd3);
    end
    continue_button = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("release4_partial", 1'b0, 1'b1, 8'd3);
    end
    reset = 1'b0;
    #1;
    check_out("mid_reset", 1'b0, 1'b0, 8'd0);
    check("mid_reset_btn_db", {31'd0, dut.u_debounce.btn_db}, 32'd0);
    tick();
    tick();
    check_out("mid_reset_hold", 1'b0, 1'b0, 8'd0);
    reset = 1'b1;
    #1;
    check_out("post_reset", 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_out("post_reset_run", 1'b1, 1'b0, 8'd0);
    end

`ifdef FETCH_CTRL_STEP_EN
    // Single step: one instruction, then HALT; each release gives one more.
    step_mode = 1'b1;
    #1;
    check_out("step_first_en", 1'b1, 1'b0, 8'd0);
    tick();
    check_out("step_first_halt", 1'b0, 1'b1, 8'd0);
    for (int k = 0; k < 3; k++) begin
      continue_button = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
      end
      check_out("step_press", 1'b0, 1'b1, 8'd0);
      continue_button = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (pc_en) begin
          pulses++;
        end
      end
      check("step_pulses", pulses, 32'd1);
      check_out("step_rehalt", 1'b0, 1'b1, 8'd0);
    end
    step_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_ctrl
